uart_rx_ctrl: RTL and testbench

- Control and deserializer stage of the UART receiver; sits directly around the RX data-sampling stage.
- Detects the start bit on RX_IN and generates per-bit timing (edge_cnt) plus the sampling enable (data_samp_en) that drive the sampler.
- Consumes the sampler's majority-voted sampled_bit at the end of each bit period, shifts data in LSB first, checks optional parity and the stop bit, and presents the received byte with a one-cycle valid strobe.

---
 rtl/uart_rx_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver control and deserializer: start detection, per-bit timing for the
// sampling stage, LSB-first shift-in, optional parity and stop-bit checking.
module uart_rx_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PRESC_W = 6
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               sampled_bit,
    output logic               data_samp_en,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [DATA_W-1:0]  P_DATA,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err,
    output logic               strt_glitch,
    output logic               busy
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]         r_state;
    logic [PRESC_W-1:0] r_edge_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_p_data;
    logic [PRESC_W-1:0] r_presc;
    logic               r_par_en;
    logic               r_par_typ;
    logic               r_par_fail;
    logic               r_data_valid;
    logic               r_par_err;
    logic               r_stp_err;
    logic               r_strt_glitch;
    logic               r_busy;

    logic [2:0]         w_state_nxt;
    logic [PRESC_W-1:0] w_edge_nxt;
    logic [BIT_W-1:0]   w_bit_nxt;
    logic [DATA_W-1:0]  w_shift_nxt;
    logic [DATA_W-1:0]  w_p_data_nxt;
    logic               w_par_fail_nxt;
    logic               w_dv_nxt;
    logic               w_pe_nxt;
    logic               w_se_nxt;
    logic               w_sg_nxt;
    logic               w_latch;
    logic               w_bit_end;
    logic               w_par_exp;

    assign w_bit_end = (r_edge_cnt == (r_presc - PRESC_W'(1)));
    assign w_par_exp = (^r_shift) ^ r_par_typ;

    // Next-state and next-output logic; decisions happen only at the last clock of a bit
    always_comb begin
        w_state_nxt    = r_state;
        w_edge_nxt     = '0;
        w_bit_nxt      = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_p_data_nxt   = r_p_data;
        w_par_fail_nxt = r_par_fail;
        w_dv_nxt       = 1'b0;
        w_pe_nxt       = 1'b0;
        w_se_nxt       = 1'b0;
        w_sg_nxt       = 1'b0;
        w_latch        = 1'b0;

        if (r_state != S_IDLE) begin
            w_edge_nxt = w_bit_end ? '0 : (r_edge_cnt + PRESC_W'(1));
        end

        case (r_state)
            S_IDLE: begin
                if (!RX_IN) begin
                    w_state_nxt = S_START;
                    w_bit_nxt   = '0;
                    w_latch     = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    if (sampled_bit) begin
                        w_state_nxt = S_IDLE;
                        w_sg_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {sampled_bit, r_shift[DATA_W-1:1]};
                    if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    if (sampled_bit != w_par_exp) begin
                        w_par_fail_nxt = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt    = S_IDLE;
                    w_par_fail_nxt = 1'b0;
                    if (!r_par_fail && sampled_bit) begin
                        w_p_data_nxt = r_shift;
                        w_dv_nxt     = 1'b1;
                    end else begin
                        w_pe_nxt = r_par_fail;
                        w_se_nxt = !sampled_bit;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_edge_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_p_data      <= '0;
            r_presc       <= '0;
            r_par_en      <= 1'b0;
            r_par_typ     <= 1'b0;
            r_par_fail    <= 1'b0;
            r_data_valid  <= 1'b0;
            r_par_err     <= 1'b0;
            r_stp_err     <= 1'b0;
            r_strt_glitch <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_edge_cnt    <= w_edge_nxt;
            r_bit_cnt     <= w_bit_nxt;
            r_shift       <= w_shift_nxt;
            r_p_data      <= w_p_data_nxt;
            r_par_fail    <= w_par_fail_nxt;
            r_data_valid  <= w_dv_nxt;
            r_par_err     <= w_pe_nxt;
            r_stp_err     <= w_se_nxt;
            r_strt_glitch <= w_sg_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            if (w_latch) begin
                r_presc   <= prescale;
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
            end
        end
    end

    assign data_samp_en = r_busy;
    assign busy         = r_busy;
    assign edge_cnt     = r_edge_cnt;
    assign P_DATA       = r_p_data;
    assign data_valid   = r_data_valid;
    assign par_err      = r_par_err;
    assign stp_err      = r_stp_err;
    assign strt_glitch  = r_strt_glitch;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frame table, corner sequences and
// randomized frames scored against a frame-level model.
module tb_uart_rx_ctrl;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned PRESC_W = 6;

    logic               clk = 1'b0;
    logic               RST;
    logic               RX_IN;
    logic [PRESC_W-1:0] prescale;
    logic               PAR_EN;
    logic               PAR_TYP;
    logic               sampled_bit = 1'b1;
    logic               data_samp_en;
    logic [PRESC_W-1:0] edge_cnt;
    logic [DATA_W-1:0]  P_DATA;
    logic               data_valid;
    logic               par_err;
    logic               stp_err;
    logic               strt_glitch;
    logic               busy;

    uart_rx_ctrl #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) dut (
        .clk          (clk),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .prescale     (prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .sampled_bit  (sampled_bit),
        .data_samp_en (data_samp_en),
        .edge_cnt     (edge_cnt),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .strt_glitch  (strt_glitch),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the sampling stage: one mid-bit sample of the line
    int p_samp = 8;
    always @(posedge clk) begin
        if (data_samp_en && edge_cnt == PRESC_W'(p_samp / 2)) sampled_bit <= RX_IN;
    end

    typedef struct {
        int          cyc;
        logic [3:0]  flags;   // {data_valid, par_err, stp_err, strt_glitch}
        logic [7:0]  pd;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];

    always @(negedge clk) begin
        if (!RST && (data_valid || par_err || stp_err || strt_glitch)) begin
            ev_t g;
            g.cyc   = cyc;
            g.flags = {data_valid, par_err, stp_err, strt_glitch};
            g.pd    = P_DATA;
            got_q.push_back(g);
        end
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    int         rx_free  = 0;
    logic [7:0] model_pd = 8'h00;

    function automatic ev_t mk(input int c, input logic [3:0] f, input logic [7:0] pd);
        ev_t e;
        e.cyc   = c;
        e.flags = f;
        e.pd    = pd;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Drives one frame onto RX_IN; det returns the clock edge the receiver sees the start on
    task automatic send_frame(input int p, input logic pe, input logic typ, input logic [7:0] d,
                              input logic pb, input logic sb, input bit corrupt, output int det);
        prescale = PRESC_W'(p);
        PAR_EN   = pe;
        PAR_TYP  = typ;
        p_samp   = p;
        RX_IN    = 1'b0;
        det      = (cyc + 1 > rx_free) ? cyc + 1 : rx_free;
        rx_free  = det + (2 + DATA_W + int'(pe)) * p + 1;
        repeat (p) @(negedge clk);
        if (corrupt) begin
            prescale = PRESC_W'(8 << $urandom_range(0, 2));
            PAR_EN   = 1'($urandom);
            PAR_TYP  = 1'($urandom);
        end
        for (int i = 0; i < DATA_W; i++) begin
            RX_IN = d[i];
            repeat (p) @(negedge clk);
        end
        if (pe) begin
            RX_IN = pb;
            repeat (p) @(negedge clk);
        end
        RX_IN = sb;
        repeat (p) @(negedge clk);
        RX_IN = 1'b1;
    endtask

    // Waits (bounded) for the expected strobes and compares them in order
    task automatic drain(input string nm);
        int budget = 4000;
        ev_t e, g;
        while (got_q.size() < exp_q.size() && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (3) @(negedge clk);
        chk({nm, " strobe count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk({nm, " strobe cycle"}, 32'(g.cyc), 32'(e.cyc));
            chk({nm, " strobe flags"}, 32'(g.flags), 32'(e.flags));
            chk({nm, " P_DATA"}, 32'(g.pd), 32'(e.pd));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    typedef struct {
        int         p;
        logic       pe, typ;
        logic [7:0] d;
        logic       pb, sb;
        logic [3:0] flags;
        logic [7:0] pd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int det, det2;
        logic [3:0] f;

        tbl[0] = '{p: 8,  pe: 1, typ: 0, d: 8'hA5, pb: 0, sb: 1, flags: 4'b1000, pd: 8'hA5};
        tbl[1] = '{p: 16, pe: 0, typ: 0, d: 8'h3C, pb: 0, sb: 1, flags: 4'b1000, pd: 8'h3C};
        tbl[2] = '{p: 8,  pe: 1, typ: 1, d: 8'h01, pb: 1, sb: 1, flags: 4'b0100, pd: 8'h3C};
        tbl[3] = '{p: 8,  pe: 0, typ: 0, d: 8'h55, pb: 0, sb: 0, flags: 4'b0010, pd: 8'h3C};
        tbl[4] = '{p: 32, pe: 1, typ: 1, d: 8'h00, pb: 1, sb: 1, flags: 4'b1000, pd: 8'h00};
        tbl[5] = '{p: 8,  pe: 1, typ: 0, d: 8'h07, pb: 0, sb: 0, flags: 4'b0110, pd: 8'h00};
        tbl[6] = '{p: 32, pe: 0, typ: 0, d: 8'hFF, pb: 0, sb: 1, flags: 4'b1000, pd: 8'hFF};
        tbl[7] = '{p: 16, pe: 1, typ: 0, d: 8'hC3, pb: 0, sb: 1, flags: 4'b1000, pd: 8'hC3};

        RST = 1'b1; RX_IN = 1'b1; prescale = PRESC_W'(8); PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset samp_en", 32'(data_samp_en), 0);
        chk("reset edge_cnt", 32'(edge_cnt), 0);
        chk("reset P_DATA", 32'(P_DATA), 0);
        chk("reset strobes", 32'({data_valid, par_err, stp_err, strt_glitch}), 0);
        RST = 1'b0;
        rx_free = cyc + 1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].p, tbl[i].pe, tbl[i].typ, tbl[i].d, tbl[i].pb, tbl[i].sb, 1'b1, det);
            exp_q.push_back(mk(det + (2 + DATA_W + int'(tbl[i].pe)) * tbl[i].p, tbl[i].flags, tbl[i].pd));
            drain($sformatf("vec%0d", i));
            chk($sformatf("vec%0d idle busy", i), 32'(busy), 0);
        end
        model_pd = 8'hC3;

        // Back-to-back frames, second start bit follows the stop bit immediately
        send_frame(16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, det);
        send_frame(16, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, det2);
        exp_q.push_back(mk(det + 160, 4'b1000, 8'h3C));
        exp_q.push_back(mk(det2 + 160, 4'b1000, 8'hC3));
        drain("b2b");
        repeat (4) @(negedge clk);

        // Short low pulse on the line is rejected as a glitch
        prescale = PRESC_W'(8); p_samp = 8;
        RX_IN = 1'b0;
        det = (cyc + 1 > rx_free) ? cyc + 1 : rx_free;
        repeat (2) @(negedge clk);
        RX_IN = 1'b1;
        rx_free = det + 8 + 1;
        exp_q.push_back(mk(det + 8, 4'b0001, model_pd));
        drain("glitch");
        chk("glitch busy", 32'(busy), 0);

        // Reset in the middle of data bit 4
        prescale = PRESC_W'(8); PAR_EN = 1'b0; p_samp = 8;
        RX_IN = 1'b0;
        det = cyc + 1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX_IN = 1'(8'h81 >> i);
            repeat (8) @(negedge clk);
        end
        RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid busy", 32'(busy), 1);
        chk("mid samp_en", 32'(data_samp_en), 1);
        chk("mid edge_cnt", 32'(edge_cnt), 32'((cyc - det) % 8));
        RST = 1'b1; RX_IN = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        chk("rst busy", 32'(busy), 0);
        chk("rst edge_cnt", 32'(edge_cnt), 0);
        chk("rst samp_en", 32'(data_samp_en), 0);
        chk("rst P_DATA", 32'(P_DATA), 0);
        got_q.delete();
        rx_free = cyc + 1;
        model_pd = 8'h00;
        repeat (2) @(negedge clk);
        send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, det);
        exp_q.push_back(mk(det + 80, 4'b1000, 8'h81));
        model_pd = 8'h81;
        drain("post-reset");

        // Randomized frames against the frame-level model
        for (int n = 0; n < 24; n++) begin
            int         p;
            logic       pe, typ, pb, sb, par_bad, stp_bad;
            logic [7:0] d;
            p   = 8 << $urandom_range(0, 2);
            pe  = 1'($urandom);
            typ = 1'($urandom);
            d   = 8'($urandom);
            pb  = (^d) ^ typ;
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            sb  = ($urandom_range(0, 6) != 0);
            send_frame(p, pe, typ, d, pb, sb, 1'b1, det);
            par_bad = pe && (pb != ((^d) ^ typ));
            stp_bad = !sb;
            if (!par_bad && !stp_bad) begin
                model_pd = d;
                f = 4'b1000;
            end else begin
                f = {1'b0, par_bad, stp_bad, 1'b0};
            end
            exp_q.push_back(mk(det + (2 + DATA_W + int'(pe)) * p, f, model_pd));
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain("random");

        chk("end busy", 32'(busy), 0);
        chk("end edge_cnt", 32'(edge_cnt), 0);
        chk("end samp_en", 32'(data_samp_en), 0);
        chk("end P_DATA", 32'(P_DATA), 32'(model_pd));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
